// File: rtl/multicycle_sequencer.sv
// Multicycle CPU control sequencer: FETCH/DECODE/EXEC/WB with fetch timeout,
// halt and fault trapping, and a wrapping retired-instruction counter.
module multicycle_sequencer #(
   parameter int unsigned WORD_SIZE   = 16,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 reset_cpu,
   input  logic                 cpu_enable,
   input  logic [3:0]           opcode,
   input  logic [5:0]           func,
   input  logic                 mem_ready,
   output logic                 mem_read,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 jmp,
   output logic                 reg_write,
   output logic                 rdst,
   output logic                 alus,
   output logic                 lhi,
   output logic                 wwd_strobe,
   output logic                 inst_done,
   output logic [WORD_SIZE-1:0] num_inst,
   output logic                 halted,
   output logic                 fault,
   output logic                 illegal,
   output logic [2:0]           state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_FAULT  = 3'd6,
      S_BAD    = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      I_ADD, I_ADI, I_LHI, I_JMP, I_WWD, I_HLT, I_ILL
   } instr_t;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t               state_q, state_d;
   logic [7:0]           wait_q, wait_d;
   logic [3:0]           op_q, op_d;
   logic [5:0]           fn_q, fn_d;
   logic [WORD_SIZE-1:0] num_q, num_d;
   instr_t               cls;
   logic                 retire;

   // Decode only ever looks at the latched instruction word.
   always_comb begin
      cls = I_ILL;
      if (op_q == 4'd15 && fn_q == 6'd0)       cls = I_ADD;
      else if (op_q == 4'd4)                   cls = I_ADI;
      else if (op_q == 4'd6)                   cls = I_LHI;
      else if (op_q == 4'd9)                   cls = I_JMP;
      else if (op_q == 4'd15 && fn_q == 6'd28) cls = I_WWD;
      else if (op_q == 4'd15 && fn_q == 6'd29) cls = I_HLT;
   end

   always_ff @(posedge clk or posedge reset_cpu) begin
      if (reset_cpu) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         op_q    <= '0;
         fn_q    <= '0;
         num_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         op_q    <= op_d;
         fn_q    <= fn_d;
         num_q   <= num_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      op_d       = op_q;
      fn_d       = fn_q;
      mem_read   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      jmp        = 1'b0;
      reg_write  = 1'b0;
      rdst       = 1'b0;
      alus       = 1'b0;
      lhi        = 1'b0;
      wwd_strobe = 1'b0;
      halted     = 1'b0;
      fault      = 1'b0;
      illegal    = 1'b0;
      retire     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cpu_enable) begin
               state_d = S_FETCH;
               wait_d  = '0;
            end
         end
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               op_d     = opcode;
               fn_d     = func;
               state_d  = S_DECODE;
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            case (cls)
               I_ADD: begin rdst = 1'b1; state_d = S_WB; end
               I_ADI: begin alus = 1'b1; state_d = S_WB; end
               I_LHI: begin lhi  = 1'b1; state_d = S_WB; end
               I_JMP: begin jmp = 1'b1; pc_write = 1'b1; retire = 1'b1; end
               I_WWD: begin wwd_strobe = 1'b1; pc_write = 1'b1; retire = 1'b1; end
               I_HLT: state_d = S_HALT;
               default: begin illegal = 1'b1; pc_write = 1'b1; retire = 1'b1; end
            endcase
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            retire    = 1'b1;
            rdst      = (cls == I_ADD);
            alus      = (cls == I_ADI);
            lhi       = (cls == I_LHI);
         end
         S_HALT:  halted = 1'b1;
         S_FAULT: fault  = 1'b1;
         default: state_d = S_IDLE;
      endcase

      // Retire overrides the per-state next state; enable is sampled only here.
      if (retire) begin
         state_d = cpu_enable ? S_FETCH : S_IDLE;
         wait_d  = '0;
      end
   end

   assign inst_done = retire;
   assign num_d     = num_q + {{(WORD_SIZE-1){1'b0}}, retire};
   assign num_inst  = num_q;
   assign state     = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: per-instruction behavioural model
// produces the expected output vector for each cycle, plus literal pins.
module tb_multicycle_sequencer;

   localparam int WS = 8;
   localparam int MT = 15;

   typedef struct packed {
      logic [2:0]    state;
      logic          mem_read, ir_write, pc_write, jmp, reg_write, rdst, alus, lhi,
                     wwd, inst_done, halted, fault, illegal;
      logic [WS-1:0] num;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_cpu = 1'b1;
   logic          cpu_enable = 1'b0;
   logic [3:0]    opcode = '0;
   logic [5:0]    func = '0;
   logic          mem_ready = 1'b0;
   logic          mem_read, ir_write, pc_write, jmp, reg_write, rdst, alus, lhi;
   logic          wwd_strobe, inst_done, halted, fault, illegal;
   logic [WS-1:0] num_inst;
   logic [2:0]    state;

   multicycle_sequencer #(.WORD_SIZE(WS), .MEM_TIMEOUT(MT)) dut (
      .clk(clk), .reset_cpu(reset_cpu), .cpu_enable(cpu_enable),
      .opcode(opcode), .func(func), .mem_ready(mem_ready),
      .mem_read(mem_read), .ir_write(ir_write), .pc_write(pc_write), .jmp(jmp),
      .reg_write(reg_write), .rdst(rdst), .alus(alus), .lhi(lhi),
      .wwd_strobe(wwd_strobe), .inst_done(inst_done), .num_inst(num_inst),
      .halted(halted), .fault(fault), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   int    n_total = 0;
   int    n_pass  = 0;
   exp_t  exp_v;
   logic  exp_valid = 1'b0;
   logic  pin_en = 1'b0;
   exp_t  pin_v;
   string pin_nm = "";
   int    pin_at[$];
   exp_t  pin_q[$];
   string pin_nq[$];
   int    tcount = 0;
   int    cnt = 0;    // model: retired count
   int    where = 0;  // model: 0 idle, 1 fetch pending, 5 halted, 6 faulted

   always @(negedge clk) begin
      exp_t d;
      if (exp_valid) begin
         d = {state, mem_read, ir_write, pc_write, jmp, reg_write, rdst, alus, lhi,
              wwd_strobe, inst_done, halted, fault, illegal, num_inst};
         n_total++;
         if (d === exp_v) n_pass++;
         else $display("FAIL model_cycle t=%0t dut=%h expected=%h", $time, d, exp_v);
         if (pin_en) begin
            n_total++;
            if (d === pin_v) n_pass++;
            else $display("FAIL pin_%s t=%0t dut=%h expected=%h", pin_nm, $time, d, pin_v);
         end
      end
   end

   function automatic exp_t blank(input logic [2:0] st);
      exp_t e;
      e = '0;
      e.state = st;
      e.num = WS'(cnt);
      e.halted = (st == 3'd5);
      e.fault = (st == 3'd6);
      return e;
   endfunction

   // Hand-written literal: bits = {mem_read,ir_write,pc_write,jmp,reg_write,rdst,alus,lhi,wwd,inst_done,halted,fault,illegal}
   function automatic exp_t mk(input logic [2:0] st, input logic [12:0] bits, input int n);
      return {st, bits, WS'(n)};
   endfunction

   function automatic logic pick(input int m);
      return (m == 2) ? 1'($urandom) : 1'(m);
   endfunction

   task automatic pin(input int off, input string nm, input exp_t v);
      pin_at.push_back(tcount + off);
      pin_q.push_back(v);
      pin_nq.push_back(nm);
   endtask

   task automatic tick(input logic en, input logic rdy, input logic [3:0] op,
                       input logic [5:0] fn, input logic rst, input exp_t e);
      cpu_enable = en; mem_ready = rdy; opcode = op; func = fn;
      exp_v = e; exp_valid = 1'b1;
      if (pin_at.size() > 0 && pin_at[0] == tcount) begin
         pin_en = 1'b1;
         pin_v = pin_q.pop_front();
         pin_nm = pin_nq.pop_front();
         void'(pin_at.pop_front());
      end
      #2 reset_cpu = rst;
      @(posedge clk); #1;
      pin_en = 1'b0;
      tcount++;
   endtask

   task automatic idle_tick(input logic en);
      tick(en, 1'($urandom), 4'($urandom), 6'($urandom), 1'b0, blank(3'd0));
      if (en) where = 1;
   endtask

   task automatic stuck_ticks(input int k);
      for (int i = 0; i < k; i++)
         tick(1'($urandom), 1'($urandom), 4'($urandom), 6'($urandom), 1'b0, blank(3'(where)));
   endtask

   task automatic do_reset();
      cnt = 0;
      tick(1'($urandom), 1'($urandom), 4'($urandom), 6'($urandom), 1'b1, blank(3'd0));
      tick(1'b0, 1'($urandom), 4'($urandom), 6'($urandom), 1'b0, blank(3'd0));
      where = 0;
   endtask

   // One instruction from FETCH entry to retire/halt/fault, per the instruction table.
   task automatic run_instr(input logic [3:0] op, input logic [5:0] fn, input int stall,
                            input int mid_en, input logic en_ret, input bit rst_wb);
      exp_t e;
      bit wb, ret;
      int n;
      n = (stall >= MT) ? MT : stall;
      for (int i = 0; i < n; i++) begin
         e = blank(3'd1); e.mem_read = 1'b1;
         tick(pick(mid_en), 1'b0, 4'($urandom), 6'($urandom), 1'b0, e);
      end
      if (stall >= MT) begin where = 6; return; end
      e = blank(3'd1); e.mem_read = 1'b1; e.ir_write = 1'b1;
      tick(pick(mid_en), 1'b1, op, fn, 1'b0, e);
      tick(pick(mid_en), 1'($urandom), 4'($urandom), 6'($urandom), 1'b0, blank(3'd2));
      e = blank(3'd3);
      wb = 0; ret = 1;
      if (op == 4'd15 && fn == 6'd0)       begin e.rdst = 1'b1; wb = 1; end
      else if (op == 4'd4)                 begin e.alus = 1'b1; wb = 1; end
      else if (op == 4'd6)                 begin e.lhi = 1'b1; wb = 1; end
      else if (op == 4'd9)                 begin e.jmp = 1'b1; e.pc_write = 1'b1; end
      else if (op == 4'd15 && fn == 6'd28) begin e.wwd = 1'b1; e.pc_write = 1'b1; end
      else if (op == 4'd15 && fn == 6'd29) ret = 0;
      else                                 begin e.illegal = 1'b1; e.pc_write = 1'b1; end
      if (wb) begin
         tick(pick(mid_en), 1'($urandom), 4'($urandom), 6'($urandom), 1'b0, e);
         if (rst_wb) begin
            cnt = 0;
            tick(en_ret, 1'($urandom), 4'($urandom), 6'($urandom), 1'b1, blank(3'd0));
            tick(1'b0, 1'($urandom), 4'($urandom), 6'($urandom), 1'b0, blank(3'd0));
            where = 0;
            return;
         end
         e.state = 3'd4; e.reg_write = 1'b1; e.pc_write = 1'b1; e.inst_done = 1'b1;
         tick(en_ret, 1'($urandom), 4'($urandom), 6'($urandom), 1'b0, e);
      end else begin
         e.inst_done = ret;
         tick(ret ? en_ret : pick(mid_en), 1'($urandom), 4'($urandom), 6'($urandom), 1'b0, e);
      end
      if (!ret) begin where = 5; return; end
      cnt = (cnt + 1) % (1 << WS);
      where = en_ret ? 1 : 0;
   endtask

   initial begin
      logic [3:0] op;
      logic [5:0] fn;
      int r, st;
      @(posedge clk); #1;
      pin(0, "reset", mk(3'd0, 13'b0, 0));
      do_reset();
      idle_tick(1'b1);

      // ADI 16'h4204
      pin(0, "adi_fetch",  mk(3'd1, 13'b1100000000000, 0));
      pin(1, "adi_decode", mk(3'd2, 13'b0000000000000, 0));
      pin(2, "adi_exec",   mk(3'd3, 13'b0000001000000, 0));
      pin(3, "adi_wb",     mk(3'd4, 13'b0010101001000, 0));
      pin(4, "adi_count",  mk(3'd1, 13'b1100000000000, 1));
      run_instr(4'h4, 6'h04, 0, 1, 1'b1, 0);
      // JMP 16'h9015
      pin(2, "jmp_exec",    mk(3'd3, 13'b0011000001000, 1));
      pin(3, "jmp_refetch", mk(3'd1, 13'b1000000000000, 2));
      run_instr(4'h9, 6'h15, 0, 1, 1'b1, 0);
      // ADD with three stall cycles
      pin(2, "stall_wait", mk(3'd1, 13'b1000000000000, 2));
      pin(3, "stall_irw",  mk(3'd1, 13'b1100000000000, 2));
      pin(5, "add_exec",   mk(3'd3, 13'b0000010000000, 2));
      run_instr(4'hF, 6'h00, 3, 1, 1'b1, 0);
      // Illegal opcode B
      pin(2, "ill_exec", mk(3'd3, 13'b0010000001001, 3));
      run_instr(4'hB, 6'h2A, 0, 1, 1'b1, 0);
      // Enable dropped from DECODE onward: LHI completes, then IDLE
      pin(4, "en_drop_idle", mk(3'd0, 13'b0, 5));
      run_instr(4'h6, 6'h11, 0, 0, 1'b0, 0);
      idle_tick(1'b0);
      idle_tick(1'b1);
      // HLT 16'hf01d
      pin(2, "hlt_exec", mk(3'd3, 13'b0, 5));
      pin(3, "halt",     mk(3'd5, 13'b0000000000100, 5));
      run_instr(4'hF, 6'h1D, 0, 1, 1'b1, 0);
      stuck_ticks(3);
      do_reset();
      // Fetch timeout
      idle_tick(1'b1);
      pin(14, "to_last_fetch", mk(3'd1, 13'b1000000000000, 0));
      pin(15, "fault",         mk(3'd6, 13'b0000000000010, 0));
      run_instr(4'h4, 6'h00, MT, 2, 1'b1, 0);
      stuck_ticks(3);
      do_reset();
      // Reset asserted mid-cycle in WB
      idle_tick(1'b1);
      run_instr(4'h9, 6'h00, 0, 2, 1'b1, 0);
      pin(3, "rst_mid_wb", mk(3'd0, 13'b0, 0));
      run_instr(4'h4, 6'h01, 0, 2, 1'b1, 1);
      // Counter wrap
      idle_tick(1'b1);
      for (int i = 0; i < (1 << WS) - 1; i++) run_instr(4'h9, 6'($urandom), 0, 2, 1'b1, 0);
      pin(2, "wrap_ff", mk(3'd3, 13'b0011000001000, 255));
      run_instr(4'h9, 6'h00, 0, 2, 1'b1, 0);
      pin(0, "wrap_zero", mk(3'd1, 13'b1100000000000, 0));
      run_instr(4'h9, 6'h00, 0, 2, 1'b1, 0);

      // Randomized traffic
      for (int k = 0; k < 600; k++) begin
         case (where)
            0: idle_tick(1'($urandom_range(0, 2) != 0));
            1: begin
               r = $urandom_range(0, 19);
               fn = 6'($urandom);
               case (r)
                  0, 1:    begin op = 4'hF; fn = 6'd0; end
                  2, 3:    op = 4'h4;
                  4, 5:    op = 4'h6;
                  6, 7:    op = 4'h9;
                  8, 9:    begin op = 4'hF; fn = 6'd28; end
                  10:      begin op = 4'hF; fn = 6'd29; end
                  default: op = 4'($urandom);
               endcase
               r = $urandom_range(0, 39);
               st = (r == 0) ? MT : (r == 1) ? MT - 1 : $urandom_range(0, 4);
               run_instr(op, fn, st, 2, 1'($urandom_range(0, 3) != 0),
                         $urandom_range(0, 29) == 0);
            end
            default: begin
               stuck_ticks($urandom_range(1, 3));
               do_reset();
            end
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter WORD_SIZE, default 16, width of num_inst.
REQ-002 Parameter MEM_TIMEOUT, default 15, maximum FETCH wait in cycles before fault (legal range 1..255).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset_cpu  input  1  reset, asynchronous, active-high.
REQ-005 cpu_enable  input  1  run permission, sampled in IDLE and at retire only.
REQ-006 opcode  input  4  instruction bits [15:12] from instruction memory.
REQ-007 func  input  6  instruction bits [5:0] from instruction memory.
REQ-008 mem_ready  input  1  instruction memory data valid.
REQ-009 mem_read  output  1  fetch request.
REQ-010 ir_write  output  1  latch instruction into IR.
REQ-011 pc_write  output  1  update PC this cycle.
REQ-012 jmp  output  1  PC source = jump target when pc_write is high.
REQ-013 reg_write, rdst, alus, lhi  output  1 each  register-file and datapath controls.
REQ-014 wwd_strobe  output  1  capture output_port.
REQ-015 inst_done  output  1  retire pulse.
REQ-016 num_inst  output  WORD_SIZE  retired-instruction count.
REQ-017 halted, fault, illegal  output  1 each  status flags.
REQ-018 state  output  3  current state encoding, for debug.

Function
REQ-019 The state encoding SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5, FAULT=6; code 7 SHALL transition to IDLE.
REQ-020 IDLE: if cpu_enable=1 the next state SHALL be FETCH; otherwise the block SHALL remain in IDLE.
REQ-021 FETCH: mem_read SHALL be 1. On mem_ready=1: ir_write=1 in that same cycle, opcode/func latched internally, next state DECODE.
REQ-022 FETCH wait counter: it SHALL clear on entry to FETCH. MEM_TIMEOUT consecutive cycles with mem_ready=0 SHALL move the block to FAULT.
REQ-023 DECODE: one cycle, all strobes 0, next state EXEC. All decode SHALL use the latched opcode/func, never the live inputs.
REQ-024 EXEC behaviour by instruction:
  - ADD (opcode 15, func 0): rdst=1, alus=0; next state WB.
  - ADI (opcode 4): alus=1; next state WB.
  - LHI (opcode 6): lhi=1; next state WB.
  - JMP (opcode 9): jmp=1, pc_write=1, retire.
  - WWD (opcode 15, func 28): wwd_strobe=1, pc_write=1, retire.
  - HLT (opcode 15, func 29): pc_write=0; next state HALT; no retire.
  - Any other encoding: illegal=1 for one cycle, pc_write=1, retire, no register write.
REQ-025 WB: reg_write=1, pc_write=1, retire. rdst/alus/lhi SHALL hold their EXEC values through WB.
REQ-026 Retire cycle: inst_done=1, and num_inst SHALL increment at the next edge, wrapping from 2^WORD_SIZE-1 to 0.
REQ-027 After retire, the next state SHALL be FETCH if cpu_enable=1, else IDLE.
REQ-028 cpu_enable going low mid-instruction SHALL NOT abort the instruction.
REQ-029 HALT: halted=1 and all strobes 0 until reset.
REQ-030 FAULT: fault=1, mem_read=0, all strobes 0 until reset.
REQ-031 Outputs SHALL be Moore decodes of state and the latched instruction, with the sole exception of ir_write, which also depends on mem_ready.
REQ-032 At most one of pc_write with jmp=0, pc_write with jmp=1, or no pc_write SHALL occur per instruction. reg_write and wwd_strobe SHALL never be high together.

Reset
REQ-033 reset_cpu=1 SHALL immediately force state=IDLE, num_inst=0, the wait counter to 0, the latched instruction to 0, and every output to 0, regardless of the current state.
REQ-034 After reset_cpu deasserts, the first FETCH SHALL occur no earlier than the second rising edge with cpu_enable=1.

Verification
REQ-035 Bench scenario, ADI: fetch 16'h4204 with mem_ready high at the first FETCH cycle -> FETCH, DECODE, EXEC(alus=1), WB(reg_write=1, pc_write=1, inst_done=1); num_inst 0->1; 4 cycles total.
REQ-036 Bench scenario, JMP: 16'h9015 -> EXEC with jmp=1, pc_write=1, reg_write=0; retire in 3 cycles; back to FETCH.
REQ-037 Bench scenario, memory stall: mem_ready low for 3 cycles then high -> mem_read high 4 cycles, single ir_write pulse. mem_ready never high -> FAULT after exactly 15 cycles, fault=1, mem_read=0.
REQ-038 Bench scenario, HLT and illegal: HLT (16'hf01d) -> HALT, halted=1, num_inst unchanged. Opcode 4'hB -> illegal pulse, inst_done=1, no reg_write.
REQ-039 Bench scenario, enable and wrap: cpu_enable dropped during DECODE -> instruction completes, then IDLE. With num_inst preloaded to 16'hFFFF via run, one retire -> 16'h0000.
REQ-040 Bench scenario, reset mid-WB: reset_cpu asserted mid-cycle in WB -> outputs 0 before the next edge, state=IDLE, num_inst=0.
